pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. It drives the enable and bubble controls of the PC register and the FD, DX, XM and MW latches. It covers three cases: multi-cycle mul/div stalls (with a handshake to the multdiv unit), load-use interlocks and taken-branch squashes. It sits beside the latch chain in the processor top; it holds no datapath and only observes instruction words.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/md_sequencer.sv | 71 +++++++
 rtl/pipe_ctrl.sv | 109 ++++++++++
 tb/tb_pipe_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared decode constants, field positions and sequencer state type for pipe_ctrl.
package pipe_ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;
  localparam int ALU_HI = 6;
  localparam int ALU_LO = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [31:0] ir);
    return (ir[OPC_HI:OPC_LO] == OP_RTYPE) &&
           ((ir[ALU_HI:ALU_LO] == ALU_MUL) || (ir[ALU_HI:ALU_LO] == ALU_DIV));
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// Mul/div handshake FSM with a bounded wait: launch, run until ready or timeout, then one done cycle.
module md_sequencer #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic is_md,
  input  logic md_ready,
  output logic md_start,
  output logic md_busy,
  output logic md_timeout,
  output logic freeze,
  output logic idle
);
  import pipe_ctrl_pkg::*;

  localparam int TW = $clog2(MD_TIMEOUT + 1);

  state_t        state, state_next;
  logic [TW-1:0] tcnt, tcnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_next;
      tcnt  <= tcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    tcnt_next  = tcnt;
    md_start   = 1'b0;
    md_busy    = 1'b0;
    md_timeout = 1'b0;
    freeze     = 1'b0;
    idle       = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (is_md) begin
          md_start   = 1'b1;
          freeze     = 1'b1;
          tcnt_next  = TW'(MD_TIMEOUT);
          state_next = MD_RUN;
        end
      end
      MD_RUN: begin
        md_busy   = 1'b1;
        freeze    = 1'b1;
        tcnt_next = tcnt - TW'(1);
        if (md_ready) begin
          state_next = MD_DONE;
        end else if (tcnt <= TW'(1)) begin
          // Unit never answered: leave anyway so the pipeline cannot hang.
          md_timeout = 1'b1;
          state_next = MD_DONE;
        end
      end
      MD_DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: mul/div stalls, load-use interlocks, taken-branch squashes.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      fd_ir,
  input  logic [31:0]      dx_ir,
  input  logic             br_taken,
  input  logic             md_ready,
  output logic             md_start,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_bubble,
  output logic             dx_bubble,
  output logic             xm_bubble,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import pipe_ctrl_pkg::*;

  logic dx_is_md, dx_is_lw, fd_is_rtype, load_use;
  logic seq_start, seq_busy, seq_timeout, freeze, idle;
  logic unused_bits;

  assign dx_is_md    = is_muldiv(dx_ir);
  assign dx_is_lw    = (dx_ir[OPC_HI:OPC_LO] == OP_LW);
  assign fd_is_rtype = (fd_ir[OPC_HI:OPC_LO] == OP_RTYPE);
  assign load_use    = dx_is_lw && (dx_ir[RD_HI:RD_LO] != 5'd0) &&
                       ((dx_ir[RD_HI:RD_LO] == fd_ir[RS_HI:RS_LO]) ||
                        (fd_is_rtype && (dx_ir[RD_HI:RD_LO] == fd_ir[RT_HI:RT_LO])));

  assign unused_bits = ^{fd_ir[26:22], fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

  md_sequencer #(
    .MD_TIMEOUT(MD_TIMEOUT)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .is_md     (dx_is_md),
    .md_ready  (md_ready),
    .md_start  (seq_start),
    .md_busy   (seq_busy),
    .md_timeout(seq_timeout),
    .freeze    (freeze),
    .idle      (idle)
  );

  // Reset forces a free-running, bubble-free pipeline regardless of the inputs.
  always_comb begin
    pc_en      = 1'b1;
    fd_en      = 1'b1;
    dx_en      = 1'b1;
    xm_en      = 1'b1;
    mw_en      = 1'b1;
    fd_bubble  = 1'b0;
    dx_bubble  = 1'b0;
    xm_bubble  = 1'b0;
    md_start   = 1'b0;
    md_busy    = 1'b0;
    md_timeout = 1'b0;
    if (!reset) begin
      md_start   = seq_start;
      md_busy    = seq_busy;
      md_timeout = seq_timeout;
      if (freeze) begin
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        dx_en     = 1'b0;
        xm_bubble = 1'b1;
      end else if (idle && br_taken) begin
        fd_bubble = 1'b1;
        dx_bubble = 1'b1;
      end else if (idle && load_use) begin
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        dx_bubble = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en) stall_q <= stall_q + CNT_W'(1);
      if (fd_bubble || dx_bubble) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; control outputs are compared as one packed vector per cycle.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fd_ir, dx_ir;
  logic        br_taken, md_ready;
  logic        md_start, pc_en, fd_en, dx_en, xm_en, mw_en;
  logic        fd_bubble, dx_bubble, xm_bubble, md_busy, md_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  // {pc,fd,dx,xm,mw enables | fd,dx,xm bubbles | md_start, md_busy, md_timeout}
  logic [10:0] ctl;
  assign ctl = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_bubble, dx_bubble, xm_bubble,
                md_start, md_busy, md_timeout};

  localparam logic [10:0] RUN_ALL = 11'b11111_000_000;
  localparam logic [10:0] LAUNCH  = 11'b00011_001_100;
  localparam logic [10:0] MDRUN   = 11'b00011_001_010;
  localparam logic [10:0] MDTMO   = 11'b00011_001_011;
  localparam logic [10:0] BRANCH  = 11'b11111_110_000;
  localparam logic [10:0] LDUSE   = 11'b00111_010_000;

  localparam logic [31:0] MUL3   = 32'h00C22018;
  localparam logic [31:0] DIV3   = 32'h00C2201C;
  localparam logic [31:0] LW4    = 32'h41020000;
  localparam logic [31:0] LW0    = 32'h40020000;
  localparam logic [31:0] ADD_RS = 32'h01482000;
  localparam logic [31:0] ADD_RT = 32'h01444000;
  localparam logic [31:0] ADD_R0 = 32'h01402000;
  localparam logic [31:0] IMM_RT = 32'h29444000;
  localparam logic [31:0] LW_RS  = 32'h41480000;

  pipe_ctrl #(.MD_TIMEOUT(8), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .fd_ir     (fd_ir),
    .dx_ir     (dx_ir),
    .br_taken  (br_taken),
    .md_ready  (md_ready),
    .md_start  (md_start),
    .pc_en     (pc_en),
    .fd_en     (fd_en),
    .dx_en     (dx_en),
    .xm_en     (xm_en),
    .mw_en     (mw_en),
    .fd_bubble (fd_bubble),
    .dx_bubble (dx_bubble),
    .xm_bubble (xm_bubble),
    .md_busy   (md_busy),
    .md_timeout(md_timeout),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; dx_ir = '0; fd_ir = '0; br_taken = 1'b0; md_ready = 1'b0;
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; dx_ir = MUL3; fd_ir = ADD_RS; br_taken = 1'b1; md_ready = 1'b1;
    #1;
    total++;
    if (ctl !== RUN_ALL) begin bad++; $display("[TB] FAIL reset_ctl got %b want %b", ctl, RUN_ALL); end
    @(negedge clk); #1;
    total++;
    if (ctl !== RUN_ALL) begin bad++; $display("[TB] FAIL reset_hold got %b want %b", ctl, RUN_ALL); end
    total++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      bad++; $display("[TB] FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    dx_ir = '0; fd_ir = '0; br_taken = 1'b0; md_ready = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (ctl !== RUN_ALL) begin bad++; $display("[TB] FAIL reset_release got %b want %b", ctl, RUN_ALL); end
  endtask

  // Mul launch, md_ready on the 5th MD_RUN cycle, MD_DONE, then a stray md_ready in IDLE.
  task automatic test_mul();
    logic [10:0] want [0:8];
    want = '{LAUNCH, MDRUN, MDRUN, MDRUN, MDRUN, MDRUN, RUN_ALL, RUN_ALL, RUN_ALL};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      dx_ir    = (k <= 6) ? MUL3 : 32'h0;
      fd_ir    = '0;
      md_ready = (k == 5 || k == 7);
      #1;
      total++;
      if (ctl !== want[k]) begin bad++; $display("[TB] FAIL mul k=%0d got %b want %b", k, ctl, want[k]); end
    end
    md_ready = 1'b0;
  endtask

  task automatic test_load_use();
    logic [31:0] dxv  [0:6];
    logic [31:0] fdv  [0:6];
    logic [10:0] want [0:6];
    dxv  = '{LW4,    32'h0,  LW4,    LW4,    LW0,    LW4,   LW4};
    fdv  = '{ADD_RS, ADD_RS, ADD_RT, IMM_RT, ADD_R0, LW_RS, 32'h0};
    want = '{LDUSE,  RUN_ALL, LDUSE, RUN_ALL, RUN_ALL, LDUSE, RUN_ALL};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      dx_ir = dxv[k]; fd_ir = fdv[k];
      #1;
      total++;
      if (ctl !== want[k]) begin bad++; $display("[TB] FAIL load_use k=%0d got %b want %b", k, ctl, want[k]); end
    end
    dx_ir = '0; fd_ir = '0;
  endtask

  task automatic test_branch();
    logic [31:0] dxv  [0:7];
    logic [31:0] fdv  [0:7];
    logic        brv  [0:7];
    logic        rdyv [0:7];
    logic [10:0] want [0:7];
    dxv  = '{32'h0,  32'h0,   LW4,    MUL3,   MUL3,  MUL3,  MUL3,    32'h0};
    fdv  = '{32'h0,  32'h0,   ADD_RS, 32'h0,  32'h0, 32'h0, 32'h0,   32'h0};
    brv  = '{1'b1,   1'b0,    1'b1,   1'b0,   1'b1,  1'b1,  1'b0,    1'b0};
    rdyv = '{1'b0,   1'b0,    1'b0,   1'b0,   1'b0,  1'b1,  1'b0,    1'b0};
    want = '{BRANCH, RUN_ALL, BRANCH, LAUNCH, MDRUN, MDRUN, RUN_ALL, RUN_ALL};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dx_ir = dxv[k]; fd_ir = fdv[k]; br_taken = brv[k]; md_ready = rdyv[k];
      #1;
      total++;
      if (ctl !== want[k]) begin bad++; $display("[TB] FAIL branch k=%0d got %b want %b", k, ctl, want[k]); end
    end
    br_taken = 1'b0; md_ready = 1'b0;
  endtask

  task automatic test_timeout();
    logic [10:0] want [0:10];
    want = '{LAUNCH, MDRUN, MDRUN, MDRUN, MDRUN, MDRUN, MDRUN, MDRUN, MDTMO, RUN_ALL, RUN_ALL};
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      dx_ir = (k <= 9) ? MUL3 : 32'h0;
      md_ready = 1'b0;
      #1;
      total++;
      if (ctl !== want[k]) begin bad++; $display("[TB] FAIL timeout k=%0d got %b want %b", k, ctl, want[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dxv  [0:6];
    logic        rdyv [0:6];
    logic [10:0] want [0:6];
    dxv  = '{MUL3,   MUL3,  MUL3,    DIV3,   DIV3,  DIV3,    32'h0};
    rdyv = '{1'b0,   1'b1,  1'b0,    1'b0,   1'b1,  1'b0,    1'b0};
    want = '{LAUNCH, MDRUN, RUN_ALL, LAUNCH, MDRUN, RUN_ALL, RUN_ALL};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      dx_ir = dxv[k]; md_ready = rdyv[k];
      #1;
      total++;
      if (ctl !== want[k]) begin bad++; $display("[TB] FAIL back_to_back k=%0d got %b want %b", k, ctl, want[k]); end
    end
    md_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dx_ir = MUL3;
      #1;
    end
    total++;
    if (ctl !== MDRUN) begin bad++; $display("[TB] FAIL midrun_pre got %b want %b", ctl, MDRUN); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (ctl !== RUN_ALL) begin bad++; $display("[TB] FAIL midrun_async got %b want %b", ctl, RUN_ALL); end
    @(negedge clk); #1;
    total++;
    if (ctl !== RUN_ALL) begin bad++; $display("[TB] FAIL midrun_held got %b want %b", ctl, RUN_ALL); end
    dx_ir = '0;
    reset = 1'b0;
    @(negedge clk); #1;
    total++;
    if (ctl !== RUN_ALL) begin bad++; $display("[TB] FAIL midrun_idle got %b want %b", ctl, RUN_ALL); end
  endtask

  task automatic test_perf();
    logic [31:0] want_stall, want_flush;
    pulse_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      dx_ir    = (k <= 6) ? MUL3 : 32'h0;
      md_ready = (k == 5);
      br_taken = (k == 7);
      #1;
    end
    md_ready = 1'b0; br_taken = 1'b0;
    @(negedge clk); #1;
`ifdef PIPE_CTRL_PERF_EN
    want_stall = 32'd6; want_flush = 32'd1;
`else
    want_stall = 32'd0; want_flush = 32'd0;
`endif
    total++;
    if (stall_cnt !== want_stall) begin bad++; $display("[TB] FAIL perf_stall got %0d want %0d", stall_cnt, want_stall); end
    total++;
    if (flush_cnt !== want_flush) begin bad++; $display("[TB] FAIL perf_flush got %0d want %0d", flush_cnt, want_flush); end
  endtask

  initial begin
    reset = 1'b1; fd_ir = '0; dx_ir = '0; br_taken = 1'b0; md_ready = 1'b0;
    test_reset();
    test_mul();
    test_load_use();
    test_branch();
    test_timeout();
    test_back_to_back();
    test_reset_mid_run();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
